// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences the single-cycle CPU through clear, pause/step, run and halt
// by issuing a one-cycle clock enable on the board clock; also counts issued enables.
module cpu_run_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int RST_HOLD  = 16,
    parameter int TAP0      = 10,
    parameter int TAP1      = 15,
    parameter int TAP2      = 20,
    parameter int TAP3      = 24,
    parameter int PRE_W     = 26
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [1:0]  iRate_sel,
    input  logic        iRun_sw,
    input  logic        iStep_key,
    input  logic        iClr_key,
    input  logic        iHlt,
    output logic        oCpu_en,
    output logic        oCpu_rst,
    output logic [1:0]  oState,
    output logic        oHalted,
    output logic [31:0] oCycles
);

    localparam logic [1:0] S_CLR   = 2'd0;
    localparam logic [1:0] S_PAUSE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    function automatic logic [PRE_W-1:0] low_ones(input int n);
        logic [PRE_W-1:0] m;
        m = '0;
        for (int b = 0; b < PRE_W; b++) begin
            if (b < n) m[b] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [PRE_W-1:0] MASK0 = low_ones(TAP0);
    localparam logic [PRE_W-1:0] MASK1 = low_ones(TAP1);
    localparam logic [PRE_W-1:0] MASK2 = low_ones(TAP2);
    localparam logic [PRE_W-1:0] MASK3 = low_ones(TAP3);

    logic [1:0]        step_sync;
    logic [1:0]        clr_sync;
    logic [1:0]        run_sync;
    logic [1:0]        rate_sync0;
    logic [1:0]        rate_sync1;
    logic [1:0]        key_s;
    logic [1:0]        db_level;
    logic [1:0]        key_press;
    logic [DB_W-1:0]   db_cnt [2];
    logic [PRE_W-1:0]  pre;
    logic [PRE_W-1:0]  tap_mask;
    logic              tick;
    logic              run_s;
    logic              step_press;
    logic              clr_press;
    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [31:0]       cycles_q;
    logic [31:0]       cycles_next;

    // Keys idle high, so their synchronisers reset to the released level.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            step_sync  <= 2'b11;
            clr_sync   <= 2'b11;
            run_sync   <= 2'b00;
            rate_sync0 <= 2'b00;
            rate_sync1 <= 2'b00;
        end else begin
            step_sync  <= {step_sync[0], iStep_key};
            clr_sync   <= {clr_sync[0], iClr_key};
            run_sync   <= {run_sync[0], iRun_sw};
            rate_sync0 <= iRate_sel;
            rate_sync1 <= rate_sync0;
        end
    end

    assign key_s      = {clr_sync[1], step_sync[1]};
    assign run_s      = run_sync[1];
    assign step_press = key_press[0];
    assign clr_press  = key_press[1];

    // Level flips only after DB_CYCLES consecutive disagreeing samples; press fires on 1->0.
    always_ff @(posedge iCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!iRST_n) begin
                db_level[i]  <= 1'b1;
                db_cnt[i]    <= '0;
                key_press[i] <= 1'b0;
            end else begin
                key_press[i] <= 1'b0;
                if (key_s[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_cnt[i]    <= '0;
                    db_level[i]  <= key_s[i];
                    key_press[i] <= ~key_s[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) pre <= '0;
        else         pre <= pre + 1'b1;
    end

    always_comb begin
        tap_mask = MASK0;
        case (rate_sync1)
            2'd0:    tap_mask = MASK0;
            2'd1:    tap_mask = MASK1;
            2'd2:    tap_mask = MASK2;
            default: tap_mask = MASK3;
        endcase
    end

    assign tick        = ((pre & tap_mask) == tap_mask);
    assign cycles_next = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

    // Clear beats halt, halt beats run/pause, and those beat tick/step.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state    <= S_CLR;
            oCpu_rst <= 1'b1;
            oCpu_en  <= 1'b0;
            oHalted  <= 1'b0;
            cycles_q <= '0;
            hold_cnt <= '0;
        end else begin
            oCpu_en <= 1'b0;
            if (clr_press) begin
                state    <= S_CLR;
                oCpu_rst <= 1'b1;
                oHalted  <= 1'b0;
                cycles_q <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    S_CLR: begin
                        if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                            state    <= S_PAUSE;
                            oCpu_rst <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (iHlt) begin
                            state   <= S_HALT;
                            oHalted <= 1'b1;
                        end else if (run_s) begin
                            state <= S_RUN;
                        end else if (step_press) begin
                            oCpu_en  <= 1'b1;
                            cycles_q <= cycles_next;
                        end
                    end
                    S_RUN: begin
                        if (iHlt) begin
                            state   <= S_HALT;
                            oHalted <= 1'b1;
                        end else if (!run_s) begin
                            state <= S_PAUSE;
                        end else if (tick) begin
                            oCpu_en  <= 1'b1;
                            cycles_q <= cycles_next;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign oState  = state;
    assign oCycles = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios followed by a random phase,
// all compared every cycle against a behavioural model of the run controller.
module tb_cpu_run_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rate_sel;
    logic        run_sw;
    logic        step_key;
    logic        clr_key;
    logic        hlt;
    logic        cpu_en;
    logic        cpu_rst;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cycles;

    int tests = 0;
    int fails = 0;
    int en_seen = 0;

    // Model: 0=CLR 1=PAUSE 2=RUN 3=HALT
    int          m_state;
    bit          m_rst, m_en, m_halted;
    logic [31:0] m_cycles;
    int          m_clr_age;
    longint      m_age;
    bit          q_step[$], q_clr[$], q_run[$];
    int          q_rate[$];
    bit [DB-1:0] w_step, w_clr;
    bit          lv_step, lv_clr, p_step, p_clr;

    cpu_run_ctrl #(
        .DB_CYCLES(DB), .RST_HOLD(HOLD),
        .TAP0(2), .TAP1(3), .TAP2(4), .TAP3(5), .PRE_W(26)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iRate_sel(rate_sel), .iRun_sw(run_sw),
        .iStep_key(step_key), .iClr_key(clr_key), .iHlt(hlt),
        .oCpu_en(cpu_en), .oCpu_rst(cpu_rst), .oState(state),
        .oHalted(halted), .oCycles(cycles)
    );

    always #5 clk = ~clk;

    function automatic int tapOf(input int r);
        case (r)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    // A key's accepted level changes once the last DB synchronised samples all disagree with it.
    task automatic debounce(input bit s, inout bit [DB-1:0] w, inout bit lv, output bit press);
        w = {w[DB-2:0], s};
        press = 1'b0;
        if (w == {DB{~lv}}) begin
            lv    = s;
            press = ~s;
        end
    endtask

    task automatic issueEnable();
        m_en = 1'b1;
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
    endtask

    task automatic modelStep();
        bit s_run, s_step, s_clr, tick;
        int rate;
        if (!rst_n) begin
            m_state = 0; m_rst = 1'b1; m_en = 1'b0; m_halted = 1'b0;
            m_cycles = '0; m_clr_age = 0; m_age = 0;
            q_step.delete(); q_clr.delete(); q_run.delete(); q_rate.delete();
            for (int i = 0; i < 2; i++) begin
                q_step.push_back(1'b1); q_clr.push_back(1'b1);
                q_run.push_back(1'b0);  q_rate.push_back(0);
            end
            w_step = '1; w_clr = '1; lv_step = 1'b1; lv_clr = 1'b1;
            p_step = 1'b0; p_clr = 1'b0;
        end else begin
            s_run  = q_run[0];
            s_step = q_step[0];
            s_clr  = q_clr[0];
            rate   = q_rate[0];
            tick   = ((m_age + 1) % (64'd1 << tapOf(rate))) == 0;
            m_en   = 1'b0;
            if (p_clr) begin
                m_state = 0; m_rst = 1'b1; m_halted = 1'b0; m_cycles = '0; m_clr_age = 0;
            end else begin
                case (m_state)
                    0: begin
                        m_clr_age++;
                        if (m_clr_age == HOLD) begin m_state = 1; m_rst = 1'b0; end
                    end
                    1: begin
                        if (hlt)         begin m_state = 3; m_halted = 1'b1; end
                        else if (s_run)  m_state = 2;
                        else if (p_step) issueEnable();
                    end
                    2: begin
                        if (hlt)         begin m_state = 3; m_halted = 1'b1; end
                        else if (!s_run) m_state = 1;
                        else if (tick)   issueEnable();
                    end
                    default: begin
                    end
                endcase
            end
            debounce(s_step, w_step, lv_step, p_step);
            debounce(s_clr, w_clr, lv_clr, p_clr);
            void'(q_step.pop_front()); q_step.push_back(step_key);
            void'(q_clr.pop_front());  q_clr.push_back(clr_key);
            void'(q_run.pop_front());  q_run.push_back(run_sw);
            void'(q_rate.pop_front()); q_rate.push_back(int'(rate_sel));
            m_age++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n clocks; after each edge, step the model and compare every output.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            modelStep();
            checkOutput("cyc_state",  32'(state),   32'(m_state));
            checkOutput("cyc_rst",    32'(cpu_rst), 32'(m_rst));
            checkOutput("cyc_en",     32'(cpu_en),  32'(m_en));
            checkOutput("cyc_halted", 32'(halted),  32'(m_halted));
            checkOutput("cyc_cycles", cycles,       m_cycles);
            if (cpu_en === 1'b1) en_seen++;
        end
    endtask

    initial begin
        int first_en, found, rst_cnt, start_cycles, step_hold, clr_hold;

        rst_n = 1'b0; rate_sel = 2'd0; run_sw = 1'b0;
        step_key = 1'b1; clr_key = 1'b1; hlt = 1'b0;
        applyStimulus(3);
        checkOutput("reset_state",  32'(state),   32'd0);
        checkOutput("reset_rst",    32'(cpu_rst), 32'd1);
        checkOutput("reset_en",     32'(cpu_en),  32'd0);
        checkOutput("reset_halted", 32'(halted),  32'd0);
        checkOutput("reset_cycles", cycles,       32'd0);

        en_seen = 0;
        rst_n = 1'b1;
        applyStimulus(3);
        checkOutput("hold_still_clr", 32'(cpu_rst), 32'd1);
        applyStimulus(1);
        checkOutput("hold_to_pause", 32'(state),   32'd1);
        checkOutput("hold_rst_low",  32'(cpu_rst), 32'd0);
        checkOutput("hold_no_en",    32'(en_seen), 32'd0);

        // Single step: one enable 7 clocks after the key falls
        applyStimulus(3);
        en_seen = 0; first_en = 0;
        step_key = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1);
            if (cpu_en === 1'b1 && first_en == 0) first_en = k;
        end
        step_key = 1'b1;
        applyStimulus(10);
        checkOutput("step_latency", 32'(first_en), 32'd7);
        checkOutput("step_pulses",  32'(en_seen),  32'd1);
        checkOutput("step_cycles",  cycles,        32'd1);

        en_seen = 0;
        step_key = 1'b0;
        applyStimulus(3);
        step_key = 1'b1;
        applyStimulus(12);
        checkOutput("glitch_no_pulse", 32'(en_seen), 32'd0);

        // Free run at rate 0: one enable every 4 clocks
        rate_sel = 2'd0; run_sw = 1'b1;
        applyStimulus(4);
        checkOutput("run_state", 32'(state), 32'd2);
        en_seen = 0; start_cycles = int'(cycles);
        applyStimulus(40);
        checkOutput("run_pulses", 32'(en_seen), 32'd10);
        checkOutput("run_cycles", cycles - 32'(start_cycles), 32'd10);
        run_sw = 1'b0;
        applyStimulus(4);
        checkOutput("pause_state", 32'(state), 32'd1);
        en_seen = 0;
        applyStimulus(20);
        checkOutput("pause_no_pulses", 32'(en_seen), 32'd0);

        // Halt raised exactly on a tick cycle
        run_sw = 1'b1;
        applyStimulus(6);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            applyStimulus(1);
            if (cpu_en === 1'b1) found = 1;
        end
        checkOutput("halt_tick_found", 32'(found), 32'd1);
        applyStimulus(3);
        hlt = 1'b1;
        applyStimulus(1);
        checkOutput("halt_en_dropped", 32'(cpu_en), 32'd0);
        checkOutput("halt_state",      32'(state),  32'd3);
        checkOutput("halt_flag",       32'(halted), 32'd1);
        hlt = 1'b0;
        start_cycles = int'(cycles); en_seen = 0;
        applyStimulus(20);
        step_key = 1'b0; applyStimulus(8); step_key = 1'b1; applyStimulus(10);
        checkOutput("halt_no_en",     32'(en_seen), 32'd0);
        checkOutput("halt_frozen",    cycles,       32'(start_cycles));
        checkOutput("halt_stays",     32'(state),   32'd3);

        // Clear from HALT
        run_sw = 1'b0;
        clr_key = 1'b0; first_en = 0; rst_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1);
            if (state === 2'd0 && first_en == 0) begin
                first_en = k;
                checkOutput("clr_cycles_zero", cycles,       32'd0);
                checkOutput("clr_halted_low",  32'(halted),  32'd0);
            end
            if (cpu_rst === 1'b1) rst_cnt++;
            if (k == 10) clr_key = 1'b1;
        end
        checkOutput("clr_latency",  32'(first_en), 32'd7);
        checkOutput("clr_rst_len",  32'(rst_cnt),  32'd4);
        checkOutput("clr_to_pause", 32'(state),    32'd1);

        // Clear during RUN
        run_sw = 1'b1;
        applyStimulus(12);
        clr_key = 1'b0; rst_cnt = 0; found = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1);
            if (state === 2'd0 && found == 0) begin
                found = 1;
                checkOutput("clrrun_en_off",  32'(cpu_en), 32'd0);
                checkOutput("clrrun_cycles0", cycles,      32'd0);
            end
            if (cpu_rst === 1'b1) rst_cnt++;
            if (k == 10) clr_key = 1'b1;
        end
        checkOutput("clrrun_seen",    32'(found),   32'd1);
        checkOutput("clrrun_rst_len", 32'(rst_cnt), 32'd4);
        run_sw = 1'b0;
        applyStimulus(5);

        // Saturation of the enable counter
        force dut.cycles_q = 32'hFFFF_FFFE;
        m_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.cycles_q;
        applyStimulus(2);
        checkOutput("sat_preload", cycles, 32'hFFFF_FFFE);
        en_seen = 0;
        for (int s = 0; s < 3; s++) begin
            step_key = 1'b0; applyStimulus(8);
            step_key = 1'b1; applyStimulus(8);
        end
        checkOutput("sat_steps", 32'(en_seen), 32'd3);
        checkOutput("sat_value", cycles,       32'hFFFF_FFFF);

        // Reset asserted mid-run
        run_sw = 1'b1;
        applyStimulus(10);
        rst_n = 1'b0;
        applyStimulus(1);
        checkOutput("midrst_state", 32'(state),  32'd0);
        checkOutput("midrst_en",    32'(cpu_en), 32'd0);
        rst_n = 1'b1;
        applyStimulus(6);

        // Random phase
        step_hold = 0; clr_hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 29) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 99) == 0) rate_sel = 2'($urandom_range(0, 3));
            if (step_hold > 0) step_hold--;
            else if ($urandom_range(0, 19) == 0) step_hold = int'($urandom_range(1, 9));
            if (clr_hold > 0) clr_hold--;
            else if ($urandom_range(0, 149) == 0) clr_hold = int'($urandom_range(1, 9));
            step_key = (step_hold == 0);
            clr_key  = (clr_hold == 0);
            hlt      = ($urandom_range(0, 399) == 0);
            applyStimulus(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
